// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mem_arb_pkg
// Brief   : Shared types and constants for the unified memory port arbiter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arbState_t;

  // Transaction owner encoding
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Default memory cycles per access and width of the beat down-counter
  localparam int DEFAULT_LATENCY = 4;
  localparam int COUNT_W         = 4;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : mem_port_arbiter
// Brief   : Shares one memory port between instruction fetch (I) and data
//           access (D). Each access occupies LATENCY memory cycles followed
//           by a one-cycle completion strobe to the owning requester.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Beat counter load value: counts LATENCY-1 down to 0 across the busy cycles
  localparam logic [COUNT_W-1:0] c_countLoad = COUNT_W'(LATENCY - 1);

  arbState_t           r_state;
  arbState_t           w_nextState;
  logic                r_owner;
  logic                r_we;
  logic                r_lastOwner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_iData;
  logic [DATA_W-1:0]   r_dRdata;
  logic [COUNT_W-1:0]  r_count;
  logic                w_grant;
  logic                w_grantOwner;
  logic                w_busy;
  logic                w_lastBeat;

  assign w_busy     = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_lastBeat = w_busy && (r_count == '0);

  // Held transaction fields drive the memory address/data directly, so they
  // stay stable in IDLE and DONE.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_data    = r_iData;
  assign d_rdata   = r_dRdata;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Arbitration, next-state and handshake/strobe outputs
  always_comb begin
    w_nextState  = r_state;
    w_grant      = 1'b0;
    w_grantOwner = OWN_I;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && d_req) begin
          // Conflict: alternate away from whoever was served last
          w_grant      = 1'b1;
          w_grantOwner = (r_lastOwner == OWN_I) ? OWN_D : OWN_I;
        end else if (i_req) begin
          w_grant      = 1'b1;
          w_grantOwner = OWN_I;
        end else if (d_req) begin
          w_grant      = 1'b1;
          w_grantOwner = OWN_D;
        end
        if (w_grant) w_nextState = (w_grantOwner == OWN_D) ? BUSY_D : BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        mem_read  = !r_we;
        mem_write = r_we;
        if (w_lastBeat) w_nextState = DONE;
      end
      DONE: begin
        i_ready     = (r_owner == OWN_I);
        d_ready     = (r_owner == OWN_D);
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Latch the granted transaction and run the beat counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= OWN_I;
      r_we        <= 1'b0;
      r_lastOwner <= OWN_I;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_count     <= '0;
    end else if (w_grant) begin
      r_owner     <= w_grantOwner;
      r_lastOwner <= w_grantOwner;
      r_count     <= c_countLoad;
      if (w_grantOwner == OWN_D) begin
        r_we    <= d_we;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
      end else begin
        // Fetches never write; write data keeps its last value
        r_we    <= 1'b0;
        r_addr  <= i_addr;
      end
    end else if (w_busy && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Capture read data into the owner's register on the final busy cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iData  <= '0;
      r_dRdata <= '0;
    end else if (w_lastBeat && !r_we) begin
      if (r_owner == OWN_D) r_dRdata <= mem_rdata;
      else                  r_iData  <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_mem_port_arbiter
// Brief   : Self-checking bench for mem_port_arbiter (LATENCY=4 and 1 builds).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready, mem_read, mem_write;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // Second build with single-cycle latency (fetch side only)
  logic        iReq1;
  logic [15:0] iAddr1;
  logic        iReady1, dReady1, memRead1, memWrite1;
  logic [15:0] iData1, dRdata1, memAddr1, memWdata1, memRdata1;

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;
  int rdRun = 0;

  always #5 clk = ~clk;

  // Memory contents as seen by the bench
  function automatic logic [15:0] memVal(input logic [15:0] a);
    case (a)
      16'h0010: memVal = 16'hA123;
      16'h0200: memVal = 16'hD200;
      default:  memVal = a ^ 16'h5EED;
    endcase
  endfunction

  // Memory only presents valid data in the last of LAT consecutive read cycles
  assign mem_rdata = (mem_read && rdRun == LAT - 1) ? memVal(mem_addr) : 16'hDEAD;
  assign memRdata1 = memRead1 ? memVal(memAddr1) : 16'hBEEF;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) u0 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(iReq1), .i_addr(iAddr1), .i_ready(iReady1), .i_data(iData1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_ready(dReady1), .d_rdata(dRdata1),
    .mem_read(memRead1), .mem_write(memWrite1), .mem_addr(memAddr1),
    .mem_wdata(memWdata1), .mem_rdata(memRdata1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdRun <= 0;
    else          rdRun <= mem_read ? rdRun + 1 : 0;
  end

  // ---------------- transaction-level reference model ----------------
  bit          mHave = 1'b0;
  bit          mOwner = 1'b0;   // 1 = D
  bit          mLast = 1'b0;
  bit          mWe = 1'b0;
  int          gCyc = 0;        // cycle in which the granted request was sampled
  logic [15:0] mAddr = '0, eAddr = '0, eWdata = '0, eIData = '0, eDRdata = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mHave = 1'b0; mLast = 1'b0;
      eAddr = '0; eWdata = '0; eIData = '0; eDRdata = '0;
    end else begin
      // Completion of a read: data registered at the end of the last memory cycle
      if (mHave && cyc == gCyc + LAT && !mWe) begin
        if (mOwner) eDRdata = memVal(mAddr);
        else        eIData  = memVal(mAddr);
      end
      // The port is free from LAT+2 cycles after the previous grant
      if (!mHave || cyc >= gCyc + LAT + 2) begin
        if (i_req || d_req) begin
          mOwner = (i_req && d_req) ? !mLast : d_req;
          mLast  = mOwner;
          mHave  = 1'b1;
          gCyc   = cyc;
          mWe    = mOwner ? d_we : 1'b0;
          mAddr  = mOwner ? d_addr : i_addr;
          eAddr  = mAddr;
          if (mOwner) eWdata = d_wdata;
        end
      end
    end
  end

  int  mRel;
  bit  eAct;

  // Compare every cycle, mid-cycle
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_i_ready", i_ready, 0);
      check("rst_d_ready", d_ready, 0);
      check("rst_i_data", i_data, 0);
      check("rst_d_rdata", d_rdata, 0);
    end else begin
      mRel = cyc - gCyc;
      eAct = mHave && mRel >= 1 && mRel <= LAT;
      check("mem_read", mem_read, eAct && !mWe);
      check("mem_write", mem_write, eAct && mWe);
      check("rd_wr_exclusive", mem_read & mem_write, 0);
      check("mem_addr", mem_addr, eAddr);
      if (eAct && mWe) check("mem_wdata", mem_wdata, eWdata);
      check("i_ready", i_ready, mHave && mRel == LAT + 1 && !mOwner);
      check("d_ready", d_ready, mHave && mRel == LAT + 1 && mOwner);
      check("i_data", i_data, eIData);
      check("d_rdata", d_rdata, eDRdata);
    end
  end

  // ---------------- directed stimulus ----------------
  int rel, nRd, nWr, firstRd, who, c0;
  logic [15:0] seenAddr, seenWdata;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitReady(input bit sideD, input int start, output int relC, output int rdN,
                           output int wrN, output int firstR, output logic [15:0] sAddr,
                           output logic [15:0] sWdata);
    relC = -1; rdN = 0; wrN = 0; firstR = -1; sAddr = '0; sWdata = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        sAddr = mem_addr;
        sWdata = mem_wdata;
        if (firstR < 0) firstR = cyc - start;
      end
      if (mem_read)  rdN++;
      if (mem_write) wrN++;
      if (sideD ? d_ready : i_ready) begin
        relC = cyc - start;
        break;
      end
    end
  endtask

  task automatic waitAny(input int start, output int side, output int relC);
    side = -1; relC = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        side = d_ready ? 1 : 0;
        relC = cyc - start;
        break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    iReq1 = 0; iAddr1 = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_mem_read_lit", mem_read, 0);
    check("reset_i_data_lit", i_data, 0);
    reset_n = 1'b1;
    tick();

    // Single fetch
    tick();
    i_addr = 16'h0010; i_req = 1; c0 = cyc;
    waitReady(0, c0, rel, nRd, nWr, firstRd, seenAddr, seenWdata);
    check("t1_ready_cycle", rel, 5);
    check("t1_read_cycles", nRd, 4);
    check("t1_first_read", firstRd, 1);
    check("t1_addr", seenAddr, 16'h0010);
    check("t1_i_data", i_data, 16'hA123);
    tick();
    i_req = 0;
    tick();

    // Simultaneous requests: D wins, then I
    tick();
    i_addr = 16'h0020; d_addr = 16'h0200; d_we = 0; i_req = 1; d_req = 1; c0 = cyc;
    waitReady(1, c0, rel, nRd, nWr, firstRd, seenAddr, seenWdata);
    check("t2_d_ready_cycle", rel, 5);
    check("t2_d_rdata", d_rdata, 16'hD200);
    tick();
    d_req = 0;
    waitReady(0, c0, rel, nRd, nWr, firstRd, seenAddr, seenWdata);
    check("t2_i_ready_cycle", rel, 11);
    check("t2_i_first_read", firstRd, 7);
    check("t2_i_read_cycles", nRd, 4);
    check("t2_i_data", i_data, 16'h5ECD);
    tick();
    i_req = 0;
    tick();

    // Continuous D requests with I pending: D, I, D
    tick();
    i_addr = 16'h0030; d_addr = 16'h0200; i_req = 1; d_req = 1; c0 = cyc;
    waitAny(c0, who, rel);
    check("t3_grant0_side", who, 1);
    check("t3_grant0_cycle", rel, 5);
    waitAny(c0, who, rel);
    check("t3_grant1_side", who, 0);
    check("t3_grant1_cycle", rel, 11);
    waitAny(c0, who, rel);
    check("t3_grant2_side", who, 1);
    check("t3_grant2_cycle", rel, 17);
    tick();
    i_req = 0; d_req = 0;
    check("t3_i_data", i_data, 16'h5EDD);
    tick();

    // D write leaves d_rdata untouched
    tick();
    d_we = 1; d_addr = 16'h0300; d_wdata = 16'h5A5A; d_req = 1; c0 = cyc;
    waitReady(1, c0, rel, nRd, nWr, firstRd, seenAddr, seenWdata);
    check("t4_ready_cycle", rel, 5);
    check("t4_write_cycles", nWr, 4);
    check("t4_read_cycles", nRd, 0);
    check("t4_addr", seenAddr, 16'h0300);
    check("t4_wdata", seenWdata, 16'h5A5A);
    check("t4_d_rdata_kept", d_rdata, 16'hD200);
    tick();
    d_req = 0; d_we = 0;
    tick();

    // Reset in the middle of a D read
    tick();
    d_addr = 16'h0200; d_req = 1; c0 = cyc;
    tick();
    tick();
    check("t5_busy_before_reset", mem_read, 1);
    reset_n = 0; d_req = 0;
    #1;
    check("t5_mem_read_reset", mem_read, 0);
    check("t5_mem_addr_reset", mem_addr, 0);
    check("t5_d_rdata_reset", d_rdata, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    tick();
    tick();
    i_addr = 16'h0010; d_addr = 16'h0200; i_req = 1; d_req = 1; c0 = cyc;
    waitAny(c0, who, rel);
    check("t5_first_side", who, 1);
    check("t5_first_cycle", rel, 5);
    tick();
    d_req = 0;
    waitAny(c0, who, rel);
    check("t5_second_side", who, 0);
    check("t5_second_cycle", rel, 11);
    check("t5_i_data", i_data, 16'hA123);
    tick();
    i_req = 0;
    tick();

    // LATENCY=1 build: back-to-back fetches every 3 cycles
    tick();
    iAddr1 = 16'h0040; iReq1 = 1; c0 = cyc;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rel = cyc - c0;
      check("l1_mem_read", memRead1, (rel % 3) == 1);
      check("l1_i_ready", iReady1, (rel % 3) == 2);
    end
    check("l1_i_data", iData1, 16'h5EAD);
    tick();
    iReq1 = 0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  // Hard stop if anything stalls
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
